// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-capturing, maskable, fixed-priority interrupt controller
//
// Collects N_SRC rising-edge interrupt sources into pending bits, masks them and
// presents the lowest-index eligible source to the processor over a 4-phase
// ExtIRQ/ExtIAck handshake. A one-cycle src_ack pulse is returned to the source
// whose request was acknowledged.
//
// Ports:
//   CLOCK_50    in   1      system clock, rising edge
//   reset       in   1      asynchronous active-low reset
//   irq_src     in   N_SRC  interrupt lines, rising-edge sensitive
//   mask_we     in   1      mask register write strobe
//   mask_wdata  in   N_SRC  new mask value, 1 = enabled
//   ExtIAck     in   1      processor acknowledge (level)
//   ExtIRQ      out  1      registered interrupt request
//   irq_id      out  ID_W   requested source index, valid while ExtIRQ=1
//   src_ack     out  N_SRC  one-cycle acknowledge pulse to the served source
//   pending     out  N_SRC  raw pending bits (before masking)

module irq_controller #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             ExtIAck,
    output logic             ExtIRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] src_ack,
    output logic [N_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [N_SRC-1:0]   mask;
    logic [N_SRC-1:0]   prev;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   clr;
    logic [N_SRC-1:0]   pending_next;
    logic [N_SRC-1:0]   src_ack_next;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    irq_id_next;
    logic               any_eligible;
    logic               ext_irq_next;

    assign rise     = irq_src & ~prev;
    assign eligible = pending & mask;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner       = ID_W'(i);
                any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        ext_irq_next = ExtIRQ;
        irq_id_next  = irq_id;
        src_ack_next = '0;
        clr          = '0;
        case (state)
            IDLE: begin
                ext_irq_next = 1'b0;
                if (any_eligible) begin
                    irq_id_next  = winner;
                    ext_irq_next = 1'b1;
                    state_next   = REQ;
                end
            end
            REQ: begin
                // irq_id is frozen here: no retraction once the request is visible.
                if (ExtIAck) begin
                    clr          = N_SRC'(1) << irq_id;
                    src_ack_next = N_SRC'(1) << irq_id;
                    ext_irq_next = 1'b0;
                    state_next   = ACKD;
                end
            end
            ACKD: begin
                ext_irq_next = 1'b0;
                if (!ExtIAck) begin
                    state_next = IDLE;
                end
            end
            default: begin
                ext_irq_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
        // A new edge arriving on the acknowledge cycle wins over the clear.
        pending_next = (pending & ~clr) | rise;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ExtIRQ  <= 1'b0;
            irq_id  <= '0;
            src_ack <= '0;
            pending <= '0;
            mask    <= '0;
            prev    <= '0;
        end else begin
            state   <= state_next;
            ExtIRQ  <= ext_irq_next;
            irq_id  <= irq_id_next;
            src_ack <= src_ack_next;
            pending <= pending_next;
            prev    <= irq_src;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller

module tb_irq_controller;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] irq_src = 4'b0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = 4'b0;
    logic       ExtIAck = 1'b0;
    logic       ExtIRQ;
    logic [1:0] irq_id;
    logic [3:0] src_ack;
    logic [3:0] pending;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending set, mask, edge history, and the handshake seen
    // from the processor side (request outstanding / waiting for ack release).
    bit [3:0] m_pend, m_mask, m_prev, m_ack;
    bit       m_irq, m_wait;
    int       m_id;

    irq_controller #(.N_SRC(4), .ID_W(2)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .irq_src   (irq_src),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .ExtIAck   (ExtIAck),
        .ExtIRQ    (ExtIRQ),
        .irq_id    (irq_id),
        .src_ack   (src_ack),
        .pending   (pending)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_prev = 0; m_ack = 0;
        m_irq = 0; m_wait = 0; m_id = 0;
    endtask

    task automatic model_edge();
        bit [3:0] rise, clr;
        int w;
        rise  = irq_src & ~m_prev;
        clr   = 0;
        m_ack = 0;
        if (m_irq) begin
            if (ExtIAck) begin
                clr[m_id]   = 1'b1;
                m_ack[m_id] = 1'b1;
                m_irq = 0;
                m_wait = 1;
            end
        end else if (m_wait) begin
            if (!ExtIAck) m_wait = 0;
        end else begin
            w = -1;
            for (int i = 0; i < 4; i++)
                if (w < 0 && m_pend[i] && m_mask[i]) w = i;
            if (w >= 0) begin
                m_irq = 1;
                m_id = w;
            end
        end
        m_pend = (m_pend & ~clr) | rise;
        if (mask_we) m_mask = mask_wdata;
        m_prev = irq_src;
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        if (reset) model_edge();
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        reset = 1'b0; irq_src = 0; ExtIAck = 0; mask_we = 0; mask_wdata = 0;
        model_reset();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic set_mask(input logic [3:0] v);
        mask_we = 1'b1; mask_wdata = v;
        step();
        mask_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; irq_src = 4'b1111; ExtIAck = 0; mask_we = 0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (ExtIRQ !== 1'b0 || pending !== 4'b0 || src_ack !== 4'b0) begin
                miscompares++;
                $display("FAIL reset_hold: ExtIRQ=%b pending=%b src_ack=%b, required 0/0000/0000", ExtIRQ, pending, src_ack);
            end
        end
        reset = 1'b1;
        step();
        vectors++;
        if (pending !== 4'b1111 || pending !== m_pend) begin
            miscompares++;
            $display("FAIL reset_release_pending: got %b, required 1111", pending);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (ExtIRQ !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_masked_noirq: ExtIRQ=%b, required 0", ExtIRQ);
            end
        end
        irq_src = 0;
    endtask

    task automatic test_single();
        do_reset();
        set_mask(4'b1111);
        irq_src = 4'b0100;
        step();
        vectors++;
        if (pending !== 4'b0100 || ExtIRQ !== 1'b0) begin
            miscompares++;
            $display("FAIL single_latch: pending=%b ExtIRQ=%b, required 0100/0", pending, ExtIRQ);
        end
        irq_src = 0;
        step();
        vectors++;
        if (ExtIRQ !== 1'b1 || irq_id !== 2'd2) begin
            miscompares++;
            $display("FAIL single_req: ExtIRQ=%b irq_id=%0d, required 1/2", ExtIRQ, irq_id);
        end
        ExtIAck = 1'b1;
        step();
        vectors++;
        if (ExtIRQ !== 1'b0 || src_ack !== 4'b0100 || pending !== 4'b0) begin
            miscompares++;
            $display("FAIL single_ack: ExtIRQ=%b src_ack=%b pending=%b, required 0/0100/0000", ExtIRQ, src_ack, pending);
        end
        step();
        vectors++;
        if (src_ack !== 4'b0 || ExtIRQ !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ack_pulse: src_ack=%b ExtIRQ=%b, required 0000/0", src_ack, ExtIRQ);
        end
        ExtIAck = 1'b0;
        step();
        step();
        vectors++;
        if (ExtIRQ !== 1'b0) begin
            miscompares++;
            $display("FAIL single_quiet: ExtIRQ=%b, required 0", ExtIRQ);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_mask(4'b1111);
        irq_src = 4'b1010;
        step();
        irq_src = 0;
        step();
        vectors++;
        if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin
            miscompares++;
            $display("FAIL prio_first: ExtIRQ=%b irq_id=%0d, required 1/1", ExtIRQ, irq_id);
        end
        ExtIAck = 1'b1;
        step();
        vectors++;
        if (src_ack !== 4'b0010 || pending !== 4'b1000) begin
            miscompares++;
            $display("FAIL prio_ack: src_ack=%b pending=%b, required 0010/1000", src_ack, pending);
        end
        ExtIAck = 1'b0;
        step();
        step();
        vectors++;
        if (ExtIRQ !== 1'b1 || irq_id !== 2'd3) begin
            miscompares++;
            $display("FAIL prio_second: ExtIRQ=%b irq_id=%0d, required 1/3", ExtIRQ, irq_id);
        end
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        step();
    endtask

    task automatic test_no_retract();
        do_reset();
        set_mask(4'b1111);
        irq_src = 4'b0100;
        step();
        irq_src = 0;
        step();
        irq_src = 4'b0001; mask_we = 1'b1; mask_wdata = 4'b1011;
        step();
        irq_src = 0; mask_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (ExtIRQ !== 1'b1 || irq_id !== 2'd2) begin
                miscompares++;
                $display("FAIL noretract_hold: ExtIRQ=%b irq_id=%0d, required 1/2", ExtIRQ, irq_id);
            end
            step();
        end
        ExtIAck = 1'b1;
        step();
        vectors++;
        if (src_ack !== 4'b0100 || pending !== 4'b0001) begin
            miscompares++;
            $display("FAIL noretract_ack: src_ack=%b pending=%b, required 0100/0001", src_ack, pending);
        end
        ExtIAck = 1'b0;
        step();
        step();
        vectors++;
        if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin
            miscompares++;
            $display("FAIL noretract_next: ExtIRQ=%b irq_id=%0d, required 1/0", ExtIRQ, irq_id);
        end
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        step();
    endtask

    task automatic test_collision();
        do_reset();
        set_mask(4'b1111);
        irq_src = 4'b0010;
        step();
        irq_src = 0;
        step();
        ExtIAck = 1'b1; irq_src = 4'b0010;
        step();
        vectors++;
        if (src_ack !== 4'b0010 || pending[1] !== 1'b1 || ExtIRQ !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_ack: src_ack=%b pending=%b ExtIRQ=%b, required 0010/x1x/0", src_ack, pending, ExtIRQ);
        end
        ExtIAck = 1'b0; irq_src = 0;
        step();
        step();
        vectors++;
        if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin
            miscompares++;
            $display("FAIL collision_rereq: ExtIRQ=%b irq_id=%0d, required 1/1", ExtIRQ, irq_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_mask(4'b1111);
        irq_src = 4'b0100;
        step();
        irq_src = 0;
        step();
        vectors++;
        if (ExtIRQ !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_setup: ExtIRQ=%b, required 1", ExtIRQ);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (ExtIRQ !== 1'b0 || src_ack !== 4'b0 || pending !== 4'b0) begin
            miscompares++;
            $display("FAIL areset_immediate: ExtIRQ=%b src_ack=%b pending=%b, required 0/0000/0000", ExtIRQ, src_ack, pending);
        end
        @(negedge CLOCK_50);
        step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (ExtIRQ !== 1'b0 || pending !== 4'b0) begin
                miscompares++;
                $display("FAIL areset_stale: ExtIRQ=%b pending=%b, required 0/0000", ExtIRQ, pending);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            irq_src    = 4'($urandom);
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = 4'($urandom);
            if (m_irq)       ExtIAck = ($urandom_range(0, 2) == 0);
            else if (m_wait) ExtIAck = ($urandom_range(0, 1) == 0);
            else             ExtIAck = ($urandom_range(0, 5) == 0);
            step();
            vectors++;
            if (ExtIRQ !== m_irq || src_ack !== m_ack || pending !== m_pend ||
                (m_irq && irq_id !== m_id[1:0])) begin
                miscompares++;
                $display("FAIL random_c%0d: ExtIRQ=%b id=%0d ack=%b pend=%b, required %b/%0d/%b/%b",
                         c, ExtIRQ, irq_id, src_ack, pending, m_irq, m_id, m_ack, m_pend);
            end
        end
        irq_src = 0; mask_we = 0; ExtIAck = 0;
    endtask

    initial begin
        model_reset();
        @(negedge CLOCK_50);
        test_reset();
        test_single();
        test_priority();
        test_no_retract();
        test_collision();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
